// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words and writes them
// to consecutive instruction-memory word addresses, holding the core in reset meanwhile.
//
// state   | meaning
// IDLE    | waiting for i_Prog_Start; core released
// RECV    | assembling bytes into a word; inter-byte timer armed while a word is partial
// WRITE   | memory write request held until granted
// DONE    | one-cycle o_Done pulse, then back to IDLE
module uart_prog_loader #(
  parameter logic [15:0] CPB      = 16'd868,
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] END_WORD = 32'h00000FFF,
  parameter logic [31:0] TIMEOUT  = 32'd100000
) (
  input  logic              i_Clock,
  input  logic              rst_ni,
  input  logic              i_Prog_Start,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic [15:0]       o_Clks_Per_Bit,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [31:0]       o_Mem_Wdata,
  input  logic              i_Mem_Gnt,
  output logic              o_Core_Rst_n,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Err
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       tmr_q, tmr_d;
  logic              mem_req_q, mem_req_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic [31:0]       word_full;

  assign o_Clks_Per_Bit = CPB;
  assign o_Mem_Req      = mem_req_q;
  assign o_Mem_Addr     = addr_q;
  assign o_Mem_Wdata    = word_q;
  assign o_Core_Rst_n   = core_rst_n_q;
  assign o_Busy         = busy_q;
  assign o_Done         = done_q;
  assign o_Err          = err_q;

  // Word as it will look once the current byte lands in the top lane.
  assign word_full = {i_Rx_Byte, word_q[23:0]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    tmr_d        = tmr_q;
    mem_req_d    = mem_req_q;
    done_d       = 1'b0;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (i_Prog_Start) begin
          state_d      = S_RECV;
          addr_d       = '0;
          byte_cnt_d   = 2'd0;
          tmr_d        = 32'd0;
          err_d        = 1'b0;
          core_rst_n_d = 1'b0;
          busy_d       = 1'b1;
        end
      end
      S_RECV: begin
        if (i_Rx_DV) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = i_Rx_Byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmr_d      = TIMEOUT - 32'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_full == END_WORD) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = S_WRITE;
              mem_req_d = 1'b1;
            end
          end
        end else if (byte_cnt_q != 2'd0) begin
          // Down-counting inter-byte timer; terminal count drops the partial word.
          if (tmr_q == 32'd0) begin
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
            err_d      = 1'b1;
          end else begin
            tmr_d = tmr_q - 32'd1;
          end
        end
      end
      S_WRITE: begin
        if (i_Rx_DV) err_d = 1'b1;
        if (i_Mem_Gnt) begin
          mem_req_d = 1'b0;
          if (addr_q == ADDR_MAX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_RECV;
          end
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        core_rst_n_d = 1'b1;
        busy_d       = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      tmr_q        <= 32'd0;
      mem_req_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      tmr_q        <= tmr_d;
      mem_req_q    <= mem_req_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes/done pulses from a
// byte-stream model, a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_prog_loader;

  localparam int          AW      = 2;
  localparam logic [31:0] ENDW    = 32'h00000FFF;
  localparam int          TMO     = 40;
  localparam int          NWORDS  = 1 << AW;

  logic          i_Clock = 1'b0;
  logic          rst_ni = 1'b0;
  logic          i_Prog_Start = 1'b0;
  logic          i_Rx_DV = 1'b0;
  logic [7:0]    i_Rx_Byte = 8'h00;
  logic [15:0]   o_Clks_Per_Bit;
  logic          o_Mem_Req;
  logic [AW-1:0] o_Mem_Addr;
  logic [31:0]   o_Mem_Wdata;
  logic          i_Mem_Gnt = 1'b0;
  logic          o_Core_Rst_n;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Err;

  uart_prog_loader #(.CPB(16'd868), .ADDR_W(AW), .END_WORD(ENDW), .TIMEOUT(TMO)) dut (
    .i_Clock(i_Clock), .rst_ni(rst_ni), .i_Prog_Start(i_Prog_Start),
    .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte), .o_Clks_Per_Bit(o_Clks_Per_Bit),
    .o_Mem_Req(o_Mem_Req), .o_Mem_Addr(o_Mem_Addr), .o_Mem_Wdata(o_Mem_Wdata),
    .i_Mem_Gnt(i_Mem_Gnt), .o_Core_Rst_n(o_Core_Rst_n), .o_Busy(o_Busy),
    .o_Done(o_Done), .o_Err(o_Err)
  );

  always #5 i_Clock = ~i_Clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_done = 0;

  // Reference model of the byte stream
  bit          m_active = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = 0;
  int          m_addr = 0;
  bit          m_err = 0;

  // 0: nothing, 1: write expected, 2: session ended by terminator
  function automatic int model_byte(input logic [7:0] b);
    if (!m_active) return 0;
    m_word[8*m_cnt +: 8] = b;
    m_cnt++;
    if (m_cnt < 4) return 0;
    m_cnt = 0;
    if (m_word == ENDW) begin
      m_active = 0;
      exp_done++;
      return 2;
    end
    exp_addr.push_back(m_addr);
    exp_data.push_back(m_word);
    if (m_addr == NWORDS - 1) begin
      m_active = 0;
      exp_done++;
    end else begin
      m_addr++;
    end
    return 1;
  endfunction

  // Grant driver: 0 = hold low, 1 = always high, 2 = random
  int gnt_mode = 1;
  initial forever begin
    @(posedge i_Clock);
    #1;
    case (gnt_mode)
      0: i_Mem_Gnt = 1'b0;
      1: i_Mem_Gnt = 1'b1;
      default: i_Mem_Gnt = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Monitor
  bit          prev_pend = 0;
  int          prev_addr = 0;
  logic [31:0] prev_data = 0;
  always @(negedge i_Clock) begin
    if (!rst_ni) begin
      prev_pend = 0;
    end else begin
      if (prev_pend && o_Mem_Req) begin
        chk("hold_addr", 32'(o_Mem_Addr), 32'(prev_addr));
        chk("hold_data", o_Mem_Wdata, prev_data);
      end
      if (o_Mem_Req && i_Mem_Gnt) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          chk("wr_addr", 32'(o_Mem_Addr), 32'(exp_addr.pop_front()));
          chk("wr_data", o_Mem_Wdata, exp_data.pop_front());
        end
      end
      if (o_Done) begin
        chk("done_expected", 32'(exp_done > 0), 32'd1);
        chk("done_core_rst", 32'(o_Core_Rst_n), 32'd0);
        if (exp_done > 0) exp_done--;
      end
      prev_pend = o_Mem_Req && !i_Mem_Gnt;
      prev_addr = int'(o_Mem_Addr);
      prev_data = o_Mem_Wdata;
    end
  end

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic wait_req_low();
    int n = 0;
    while (o_Mem_Req && n < 100) begin
      tick();
      n++;
    end
    if (o_Mem_Req) chk("req_grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_busy", 32'(o_Busy), 32'd0);
    chk("idle_core_rst", 32'(o_Core_Rst_n), 32'd1);
  endtask

  task automatic start();
    i_Prog_Start = 1'b1;
    tick();
    i_Prog_Start = 1'b0;
    if (!m_active) begin
      m_active = 1;
      m_addr = 0;
      m_cnt = 0;
      m_word = 0;
      m_err = 0;
    end
    chk("start_core_rst", 32'(o_Core_Rst_n), 32'd0);
    chk("start_busy", 32'(o_Busy), 32'd1);
    chk("start_err", 32'(o_Err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit auto_wait);
    int r;
    bit was_active;
    was_active = m_active;
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV = 1'b0;
    r = model_byte(b);
    if (r == 1) begin
      chk("req_latency", 32'(o_Mem_Req), 32'd1);
      if (auto_wait) wait_req_low();
    end else if (r == 2) begin
      chk("done_latency", 32'(o_Done), 32'd1);
    end else if (!was_active) begin
      chk("ignored_no_req", 32'(o_Mem_Req), 32'd0);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit auto_wait);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], (i == 3) ? auto_wait : 1'b1);
      if (i < 3) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic end_session();
    if (m_active) send_word(ENDW, 1'b1);
    wait_idle();
    chk("session_err", 32'(o_Err), 32'(m_err));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req", 32'(o_Mem_Req), 32'd0);
    chk("rst_done", 32'(o_Done), 32'd0);
    chk("rst_err", 32'(o_Err), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_core_rst", 32'(o_Core_Rst_n), 32'd1);
    chk("cpb", 32'(o_Clks_Per_Bit), 32'd868);
    rst_ni = 1'b1;
    repeat (2) tick();

    // Bytes in IDLE are ignored
    send_word(32'h12345678, 1'b1);
    chk("idle_busy0", 32'(o_Busy), 32'd0);

    // Basic program load
    gnt_mode = 1;
    start();
    send_word(32'h00000013, 1'b1);
    send_word(32'h00000137, 1'b1);
    end_session();

    // Grant withheld for 10 cycles
    gnt_mode = 0;
    start();
    send_word(32'hCAFEF00D, 1'b0);
    repeat (10) begin
      tick();
      chk("req_held", 32'(o_Mem_Req), 32'd1);
    end
    gnt_mode = 1;
    wait_req_low();
    end_session();

    // Inter-byte timeout
    start();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", 32'(o_Err), 32'd0);
    tick();
    chk("tmo_err", 32'(o_Err), 32'd1);
    m_cnt = 0;
    m_err = 1;
    send_word(32'h0BADBEEF, 1'b1);
    end_session();

    // Memory full, no wrap, further words ignored
    gnt_mode = 2;
    start();
    for (int i = 0; i < NWORDS; i++) send_word($urandom() | 32'h1000_0000, 1'b1);
    wait_idle();
    send_word(32'h55667788, 1'b1);
    chk("full_idle", 32'(o_Busy), 32'd0);

    // Async reset while a request is pending
    gnt_mode = 0;
    start();
    send_word(32'h11223344, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_req", 32'(o_Mem_Req), 32'd0);
    chk("async_core_rst", 32'(o_Core_Rst_n), 32'd1);
    chk("async_busy", 32'(o_Busy), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    m_active = 0;
    tick();
    rst_ni = 1'b1;
    repeat (2) tick();
    chk("post_rst_err", 32'(o_Err), 32'd0);

    // Byte arriving during a write is dropped
    start();
    send_word(32'hA5A5_0001, 1'b0);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = 8'hEE;
    tick();
    i_Rx_DV = 1'b0;
    m_err = 1;
    chk("overrun_err", 32'(o_Err), 32'd1);
    gnt_mode = 1;
    wait_req_low();
    send_word(32'h0000_2222, 1'b1);
    end_session();

    // Randomised sessions
    for (int s = 0; s < 6; s++) begin
      gnt_mode = 2;
      start();
      for (int w = 0; w < int'($urandom_range(0, 5)); w++) begin
        if (m_active) send_word($urandom(), 1'b1);
        repeat ($urandom_range(0, 4)) tick();
      end
      end_session();
    end

    repeat (5) tick();
    chk("wr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
